// File: rtl/synth_pkg.sv
// Shared types for the wavetable note sequencer.
//   seq_state_e : controller states (IDLE, PLAY, GAP)
//   step_t      : one step table entry {freq, vol, dur}
//   STEP_IDX_W  : width of a step index for the default table depth
package synth_pkg;

    localparam int FREQ_W     = 16;
    localparam int VOL_W      = 8;
    localparam int DUR_W      = 16;
    localparam int STEPS_DEF  = 16;
    localparam int STEP_IDX_W = $clog2(STEPS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [VOL_W-1:0]  vol;
        logic [DUR_W-1:0]  dur;
    } step_t;

endpackage

// File: rtl/seq_step_ram.sv
// Step table storage: STEPS entries of step_t.
// Ports:
//   clk   : clock, write on posedge
//   we    : write enable
//   waddr : write index
//   wdata : entry to store
//   raddr : read index
//   rdata : entry at raddr (combinational; a same-cycle write is not visible)
module seq_step_ram
    import synth_pkg::*;
#(
    parameter int STEPS = STEPS_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(STEPS)-1:0] waddr,
    input  step_t                    wdata,
    input  logic [$clog2(STEPS)-1:0] raddr,
    output step_t                    rdata
);

    step_t mem [STEPS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks a programmable step table and drives frequency and
// volume for the wavetable playback path. Durations and gaps are counted in
// sample periods (sample_tick pulses). All outputs are registered.
// Ports:
//   mclk, rst            : clock, asynchronous active-high reset
//   sample_tick          : one pulse per sample period
//   start, stop, loop_en : playback control
//   num_steps            : number of active steps, sampled on accepted start
//   wr_en/wr_addr/wr_*   : table write port, accepted only while idle
//   wr_err               : pulse, write rejected while busy
//   frequency, volume    : to the playback path
//   step_idx, busy, done : status
module note_sequencer
    import synth_pkg::*;
#(
    parameter int FREQ_RES_BITS = FREQ_W,
    parameter int VOLUME_BITS   = VOL_W,
    parameter int STEPS         = STEPS_DEF,
    parameter int DUR_BITS      = DUR_W,
    parameter int GAP_TICKS     = 4
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     sample_tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [$clog2(STEPS):0]   num_steps,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [FREQ_RES_BITS-1:0] wr_freq,
    input  logic [VOLUME_BITS-1:0]   wr_vol,
    input  logic [DUR_BITS-1:0]      wr_dur,
    output logic                     wr_err,
    output logic [FREQ_RES_BITS-1:0] frequency,
    output logic [VOLUME_BITS-1:0]   volume,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = $clog2(STEPS);
    localparam int NUM_W = IDX_W + 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    seq_state_e               state_q, state_nx;
    logic [DUR_BITS-1:0]      dur_cnt_q, dur_cnt_nx;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_nx;
    logic [IDX_W-1:0]         last_idx_q, last_idx_nx;
    logic [IDX_W-1:0]         rd_addr, idx_nx;
    logic [FREQ_RES_BITS-1:0] freq_nx;
    logic [VOLUME_BITS-1:0]   vol_nx;
    logic                     busy_nx, done_nx, wr_err_nx;
    logic [NUM_W-1:0]         num_clamped;
    step_t                    rd_step;
    logic                     start_ok, play_end, gap_end, advance, is_last;

    seq_step_ram #(
        .STEPS (STEPS)
    ) u_ram (
        .clk   (mclk),
        .we    (wr_en && (state_q == IDLE)),
        .waddr (wr_addr),
        .wdata ('{freq: FREQ_W'(wr_freq), vol: VOL_W'(wr_vol), dur: DUR_W'(wr_dur)}),
        .raddr (rd_addr),
        .rdata (rd_step)
    );

    assign num_clamped = (num_steps > NUM_W'(STEPS)) ? NUM_W'(STEPS) : num_steps;
    assign start_ok    = (state_q == IDLE) && start && !stop && (num_steps != '0);
    // dur_cnt never sits below 1 while playing (dur 0 is loaded as 1).
    assign play_end    = (state_q == PLAY) && sample_tick && (dur_cnt_q <= DUR_BITS'(1));
    assign gap_end     = (state_q == GAP) && sample_tick && (gap_cnt_q <= GAP_W'(1));
    assign advance     = (play_end && (GAP_TICKS == 0)) || gap_end;
    assign is_last     = (step_idx == last_idx_q);
    // Single read port: step 0 when idle or wrapping, otherwise the next step.
    assign rd_addr     = ((state_q == IDLE) || is_last) ? '0 : step_idx + IDX_W'(1);

    // State and output registers
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            last_idx_q <= '0;
            frequency  <= '0;
            volume     <= '0;
            step_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            state_q    <= state_nx;
            dur_cnt_q  <= dur_cnt_nx;
            gap_cnt_q  <= gap_cnt_nx;
            last_idx_q <= last_idx_nx;
            frequency  <= freq_nx;
            volume     <= vol_nx;
            step_idx   <= idx_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            wr_err     <= wr_err_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_nx = PLAY;
            end
            PLAY, GAP: begin
                if (stop)          state_nx = IDLE;
                else if (advance)  state_nx = (!is_last || loop_en) ? PLAY : IDLE;
                else if (play_end) state_nx = GAP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next register values for counters and outputs
    always_comb begin
        freq_nx     = frequency;
        vol_nx      = volume;
        idx_nx      = step_idx;
        dur_cnt_nx  = dur_cnt_q;
        gap_cnt_nx  = gap_cnt_q;
        last_idx_nx = last_idx_q;
        done_nx     = 1'b0;
        wr_err_nx   = wr_en && (state_q != IDLE);
        busy_nx     = (state_nx != IDLE);

        if (start_ok) begin
            freq_nx     = FREQ_RES_BITS'(rd_step.freq);
            vol_nx      = VOLUME_BITS'(rd_step.vol);
            dur_cnt_nx  = (rd_step.dur == '0) ? DUR_BITS'(1) : DUR_BITS'(rd_step.dur);
            idx_nx      = '0;
            last_idx_nx = IDX_W'(num_clamped - NUM_W'(1));
        end else if ((state_q != IDLE) && stop) begin
            freq_nx    = '0;
            vol_nx     = '0;
            idx_nx     = '0;
            dur_cnt_nx = '0;
            gap_cnt_nx = '0;
        end else if (advance) begin
            if (!is_last || loop_en) begin
                idx_nx     = rd_addr;
                freq_nx    = FREQ_RES_BITS'(rd_step.freq);
                vol_nx     = VOLUME_BITS'(rd_step.vol);
                dur_cnt_nx = (rd_step.dur == '0) ? DUR_BITS'(1) : DUR_BITS'(rd_step.dur);
                gap_cnt_nx = '0;
            end else begin
                freq_nx    = '0;
                vol_nx     = '0;
                idx_nx     = '0;
                dur_cnt_nx = '0;
                gap_cnt_nx = '0;
                done_nx    = 1'b1;
            end
        end else if (play_end) begin
            // Silence for the gap but keep the pitch.
            vol_nx     = '0;
            dur_cnt_nx = '0;
            gap_cnt_nx = GAP_W'(GAP_TICKS);
        end else if ((state_q == PLAY) && sample_tick) begin
            dur_cnt_nx = dur_cnt_q - DUR_BITS'(1);
        end else if ((state_q == GAP) && sample_tick) begin
            gap_cnt_nx = gap_cnt_q - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    import synth_pkg::*;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        rst, sample_tick, start_drv, stop_drv, loop_en, wr_drv, sel;
    logic [1:0]  wmask;
    logic [4:0]  num_steps;
    logic [3:0]  wr_addr;
    logic [15:0] wr_freq, wr_dur;
    logic [7:0]  wr_vol;

    logic        wr_err0, busy0, done0, wr_err4, busy4, done4;
    logic [15:0] freq0, freq4;
    logic [7:0]  vol0, vol4;
    logic [3:0]  idx0, idx4;

    note_sequencer #(.GAP_TICKS(0)) dut0 (
        .mclk(mclk), .rst(rst), .sample_tick(sample_tick),
        .start(start_drv && !sel), .stop(stop_drv && !sel), .loop_en(loop_en),
        .num_steps(num_steps), .wr_en(wr_drv && wmask[0]), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_vol(wr_vol), .wr_dur(wr_dur), .wr_err(wr_err0),
        .frequency(freq0), .volume(vol0), .step_idx(idx0), .busy(busy0), .done(done0)
    );

    note_sequencer #(.GAP_TICKS(4)) dut4 (
        .mclk(mclk), .rst(rst), .sample_tick(sample_tick),
        .start(start_drv && sel), .stop(stop_drv && sel), .loop_en(loop_en),
        .num_steps(num_steps), .wr_en(wr_drv && wmask[1]), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_vol(wr_vol), .wr_dur(wr_dur), .wr_err(wr_err4),
        .frequency(freq4), .volume(vol4), .step_idx(idx4), .busy(busy4), .done(done4)
    );

    logic [15:0] o_freq;
    logic [7:0]  o_vol;
    logic [3:0]  o_idx;
    logic        o_busy, o_done, o_wr_err;
    assign o_freq   = sel ? freq4 : freq0;
    assign o_vol    = sel ? vol4 : vol0;
    assign o_idx    = sel ? idx4 : idx0;
    assign o_busy   = sel ? busy4 : busy0;
    assign o_done   = sel ? done4 : done0;
    assign o_wr_err = sel ? wr_err4 : wr_err0;

    int done_cnt0 = 0;
    int done_cnt4 = 0;
    always @(posedge mclk) begin
        if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
        if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
    end

    int checks = 0;
    int failures = 0;

    // Reference table and expected per-sample-period trace
    int tf[16], tv[16], td[16];
    typedef struct { int f; int v; int s; int p; } exp_t;
    exp_t exp_q[$];
    int   nn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    // One sample period per step unit (dur 0 counts as 1), then the gap with volume 0.
    function automatic void build(input int n, input int passes, input int gap);
        exp_t e;
        exp_q.delete();
        nn = (n > 16) ? 16 : n;
        for (int p = 0; p < passes; p++) begin
            for (int s = 0; s < nn; s++) begin
                e.s = s; e.p = p; e.f = tf[s];
                e.v = tv[s];
                for (int k = 0; k < ((td[s] == 0) ? 1 : td[s]); k++) exp_q.push_back(e);
                e.v = 0;
                for (int k = 0; k < gap; k++) exp_q.push_back(e);
            end
        end
    endfunction

    task automatic write_entry(input int a, input int f, input int v, input int d);
        wr_addr = 4'(a); wr_freq = 16'(f); wr_vol = 8'(v); wr_dur = 16'(d);
        wmask = 2'b11; wr_drv = 1'b1;
        cyc();
        wr_drv = 1'b0;
        check_eq("wr_err_idle", 32'({wr_err0, wr_err4}), 0);
        tf[a] = f; tv[a] = v; td[a] = d;
    endtask

    task automatic play(input bit s, input int n, input int passes,
                        input bit wr0, input int wf, input int wv, input int wd);
        int d0, w;
        sel = s;
        build(n, passes, s ? 4 : 0);
        d0 = s ? done_cnt4 : done_cnt0;
        num_steps = 5'(n);
        loop_en = (passes > 1);
        if (wr0) begin
            wr_addr = 4'd0; wr_freq = 16'(wf); wr_vol = 8'(wv); wr_dur = 16'(wd);
            wmask = 2'b11; wr_drv = 1'b1;
        end
        start_drv = 1'b1;
        cyc();
        start_drv = 1'b0;
        wr_drv = 1'b0;
        if (wr0) begin
            tf[0] = wf; tv[0] = wv; td[0] = wd;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].p == passes - 1 && exp_q[i].s == nn - 1) loop_en = 1'b0;
            w = $urandom_range(0, 2);
            for (int k = 0; k <= w; k++) begin
                check_eq("freq", 32'(o_freq), exp_q[i].f);
                check_eq("vol", 32'(o_vol), exp_q[i].v);
                check_eq("step_idx", 32'(o_idx), exp_q[i].s);
                check_eq("busy", 32'(o_busy), 1);
                check_eq("done_early", 32'(o_done), 0);
                if (k < w) cyc();
            end
            tick();
        end
        check_eq("end_done", 32'(o_done), 1);
        check_eq("end_busy", 32'(o_busy), 0);
        check_eq("end_freq", 32'(o_freq), 0);
        check_eq("end_vol", 32'(o_vol), 0);
        check_eq("end_idx", 32'(o_idx), 0);
        cyc();
        check_eq("done_width", 32'(o_done), 0);
        check_eq("done_count", (s ? done_cnt4 : done_cnt0) - d0, 1);
    endtask

    task automatic start_only(input bit s, input int n);
        sel = s; num_steps = 5'(n); loop_en = 1'b0;
        start_drv = 1'b1;
        cyc();
        start_drv = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(o_busy), 0);
        check_eq({tag, "_freq"}, 32'(o_freq), 0);
        check_eq({tag, "_vol"}, 32'(o_vol), 0);
        check_eq({tag, "_idx"}, 32'(o_idx), 0);
        check_eq({tag, "_done"}, 32'(o_done), 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; sample_tick = 1'b0; start_drv = 1'b0; stop_drv = 1'b0;
        loop_en = 1'b0; wr_drv = 1'b0; wmask = 2'b11; sel = 1'b0;
        num_steps = '0; wr_addr = '0; wr_freq = '0; wr_vol = '0; wr_dur = '0;
        cyc();
        cyc();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check_idle("reset");
            check_eq("reset_wr_err", 32'(o_wr_err), 0);
        end
        #3 rst = 1'b0;
        cyc();

        for (int a = 0; a < 16; a++)
            write_entry(a, $urandom_range(1, 65535), $urandom_range(1, 255), $urandom_range(0, 3));
        write_entry(0, 100, 200, 3);
        write_entry(1, 50, 128, 2);
        write_entry(2, 25, 64, 1);

        // Directed playback, no gap then with gap
        play(1'b0, 3, 1, 1'b0, 0, 0, 0);
        play(1'b1, 3, 1, 1'b0, 0, 0, 0);
        // Looping, loop_en cleared during the last step of the third pass
        play(1'b0, 2, 3, 1'b0, 0, 0, 0);

        // Stop with simultaneous start, mid step 1
        start_only(1'b0, 3);
        repeat (4) tick();
        check_eq("pre_stop_idx", 32'(o_idx), 1);
        check_eq("pre_stop_freq", 32'(o_freq), 50);
        d0 = done_cnt0;
        stop_drv = 1'b1; start_drv = 1'b1;
        cyc();
        stop_drv = 1'b0; start_drv = 1'b0;
        check_idle("stop");
        cyc();
        check_eq("stop_still_idle", 32'(o_busy), 0);
        check_eq("stop_no_done", done_cnt0 - d0, 0);

        // Stop during a gap
        start_only(1'b1, 3);
        repeat (3) tick();
        check_eq("gap_vol", 32'(o_vol), 0);
        check_eq("gap_freq", 32'(o_freq), 100);
        check_eq("gap_busy", 32'(o_busy), 1);
        stop_drv = 1'b1;
        cyc();
        stop_drv = 1'b0;
        check_idle("gap_stop");

        // Write while busy is rejected
        start_only(1'b0, 3);
        wr_addr = 4'd0; wr_freq = 16'd999; wr_vol = 8'd1; wr_dur = 16'd1;
        wmask = 2'b01; wr_drv = 1'b1;
        cyc();
        wr_drv = 1'b0; wmask = 2'b11;
        check_eq("wr_err_busy", 32'(o_wr_err), 1);
        cyc();
        check_eq("wr_err_width", 32'(o_wr_err), 0);
        stop_drv = 1'b1;
        cyc();
        stop_drv = 1'b0;
        play(1'b0, 3, 1, 1'b0, 0, 0, 0);

        // num_steps == 0 start is ignored
        d0 = done_cnt0;
        start_only(1'b0, 0);
        check_eq("zero_busy", 32'(o_busy), 0);
        tick();
        cyc();
        check_eq("zero_busy2", 32'(o_busy), 0);
        check_eq("zero_no_done", done_cnt0 - d0, 0);

        // Asynchronous reset mid-play
        start_only(1'b0, 3);
        tick();
        check_eq("pre_rst_busy", 32'(o_busy), 1);
        #3 rst = 1'b1;
        #1;
        check_idle("async_rst");
        cyc();
        #3 rst = 1'b0;
        cyc();
        check_eq("post_rst_busy", 32'(o_busy), 0);
        play(1'b0, 3, 1, 1'b0, 0, 0, 0);

        // Randomized table and playback
        for (int a = 0; a < 16; a++)
            write_entry(a, $urandom_range(1, 65535), $urandom_range(1, 255), $urandom_range(0, 3));
        for (int r = 0; r < 4; r++)
            play(r[0], $urandom_range(1, 16), 1, 1'b0, 0, 0, 0);
        play(1'b1, 20, 1, 1'b0, 0, 0, 0);
        play(1'b0, $urandom_range(1, 4), 2, 1'b0, 0, 0, 0);

        // Write in the same cycle as start: start uses the old entry, write lands
        play(1'b0, 3, 1, 1'b1, 777, 33, 2);
        play(1'b0, 1, 1, 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Controller that sequences the wavetable I2S playback path: steps through a small programmable table of (frequency divider, volume, duration) entries and drives the synth's frequency and volume inputs.
Durations are counted in sample periods via a one-cycle sample_tick pulse in the mclk domain, derived from the LR clock.
The table is loaded by the PS-side register logic over a simple write port while the sequencer is idle.
Supports one-shot and looped playback, an inter-note silence gap and abort.

Parameters:
FREQ_RES_BITS, 16, width of the frequency divider driven to the playback path
VOLUME_BITS, 8, width of the volume output
STEPS, 16, depth of the step table (power of two)
DUR_BITS, 16, width of per-step duration in sample periods
GAP_TICKS, 4, silent sample periods inserted between steps (0 = no gap)

Ports:
mclk  in  1  master clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
sample_tick  in  1  one-cycle pulse per sample period, synchronous to mclk
start  in  1  pulse; begins playback at step 0
stop  in  1  pulse; aborts playback
loop_en  in  1  sampled at the end of the last step; 1 = restart at step 0
num_steps  in  $clog2(STEPS)+1  active steps, 0..STEPS; sampled on accepted start
wr_en  in  1  table write strobe
wr_addr  in  $clog2(STEPS)  table index
wr_freq  in  FREQ_RES_BITS  step frequency divider
wr_vol  in  VOLUME_BITS  step volume
wr_dur  in  DUR_BITS  step duration in sample periods
wr_err  out  1  pulse; write rejected because the sequencer was not IDLE
frequency  out  FREQ_RES_BITS  to the playback path
volume  out  VOLUME_BITS  to the playback path; 0 = silent
step_idx  out  $clog2(STEPS)  current step
busy  out  1  high in PLAY or GAP
done  out  1  one-cycle pulse when one-shot playback completes

Behaviour:
- Reset, asynchronous: state IDLE. frequency=0, volume=0, step_idx=0, busy=0, done=0, wr_err=0, all counters 0. Table contents are not reset.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - wr_en writes the table entry at wr_addr; the write is visible on the next cycle.
  - start with num_steps>0: latch num_steps, load step 0 (frequency, volume, dur_cnt=wr_dur of step 0), go to PLAY. Outputs are valid 1 cycle after start.
  - start with num_steps==0: ignored, stays IDLE, no done.
- PLAY:
  - Each sample_tick decrements dur_cnt.
  - When a tick arrives with dur_cnt==1, or on entry with dur==0 (treated as 1 period), the step ends.
  - Step end with GAP_TICKS>0: volume<=0, frequency is held, gap_cnt=GAP_TICKS, go to GAP.
  - Step end with GAP_TICKS==0: advance directly.
- GAP: each sample_tick decrements gap_cnt; at 0, advance.
- Advance:
  - If step_idx<num_steps-1: step_idx+1, load that entry, go to PLAY.
  - Else if loop_en: step_idx=0, load entry 0, go to PLAY.
  - Else: volume=0, frequency=0, step_idx=0, go to IDLE with a done pulse in the same cycle busy falls.
- Step outputs change only on the cycle after a sample_tick, never mid sample period, except on start or stop.
- stop in PLAY or GAP: the next cycle goes to IDLE, volume=0, frequency=0, step_idx=0. No done pulse.
- Simultaneous start and stop: stop wins.
- start while busy: ignored.
- wr_en while busy: no write; wr_err pulses 1 cycle.
- wr_en in the same cycle as an accepted start: the write is performed and the start loads the pre-write entry.
- sample_tick absent: the sequencer holds the current step indefinitely.
- Counter arithmetic is unsigned with no wrap; num_steps>STEPS is clamped to STEPS.

Decomposition:
- Package synth_pkg:
  - seq_state_e enum {IDLE, PLAY, GAP}
  - step_t packed struct {freq, vol, dur}, parameterised widths via package localparams matching the defaults
  - STEP_IDX_W constant
- Sub-module seq_step_ram: STEPS x step_t storage, synchronous write and combinational read port. The controller FSM stays in note_sequencer.

Test Plan:
- Load steps 0..2 = (100,200,3),(50,128,2),(25,64,1); num_steps=3, GAP_TICKS=0, loop_en=0; start -> frequency/volume go 100/200 for 3 ticks, 50/128 for 2, 25/64 for 1, then 0/0; done pulses once; busy is high for exactly 6 tick periods.
- Same table, GAP_TICKS=4 -> volume=0 for 4 ticks after each step with frequency held; done after 6+12=18 ticks.
- loop_en=1, num_steps=2 -> sequence 100,50,100,50 repeats; clearing loop_en during step 1 gives done at the end of that step.
- stop asserted mid step 1, with start asserted in the same cycle -> next cycle IDLE, volume=0, step_idx=0, no done.
- wr_en to addr 0 while busy -> wr_err pulse, and a later replay still shows 100/200. num_steps=0 start -> busy stays 0.
- rst asserted asynchronously mid-PLAY, between clock edges -> outputs 0 immediately. After release, start replays the unchanged table from step 0.
